// File: rtl/mul_c42_pipe.sv
// mul_c42_pipe: 3-stage RV32M multiplier (Baugh-Wooley partial products, 4:2 compressor tree, final add)
// Ports: clk, rst_n (async active-low); flush kills in-flight ops;
//   in_valid/in_ready/in_op/in_a/in_b/in_tag request side; out_valid/out_ready/out_data/out_tag result side.
module mul_c42_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag
);
  localparam int N = XLEN + 1;
  localparam int W = 2 * XLEN + 2;
  typedef logic [N-1:0][W-1:0] rows_t;
  function automatic int nxt(int m);
    return (m / 4) * 2 + ((m % 4 == 3) ? 2 : m % 4);
  endfunction
  function automatic int rows_after(int m, int lim);
    int r;
    r = m;
    while (r > lim) r = nxt(r);
    return r;
  endfunction
  localparam int M1 = rows_after(N, 8);
  // Baugh-Wooley rows; the correction constant 2^N + 2^(2N-1) lands in free bits of row 0
  function automatic rows_t gen_pp(logic [N-1:0] a, logic [N-1:0] b);
    rows_t r;
    r = '0;
    for (int j = 0; j < N; j++)
      for (int i = 0; i < N; i++)
        r[j][i+j] = (a[i] & b[j]) ^ ((i == N - 1) != (j == N - 1));
    r[0][N] = 1'b1;
    r[0][W-1] = 1'b1;
    return r;
  endfunction
  // One tree level over the first m rows: 4:2 rows per group of four, 3:2 row or pass-through for the rest
  function automatic rows_t reduce(rows_t r, int m);
    rows_t o;
    logic [W-1:0] t, ci;
    int k, b;
    o = '0;
    k = 0;
    b = (m / 4) * 4;
    for (int g = 0; g + 3 < N; g += 4)
      if (g + 3 < m) begin
        t = r[g] ^ r[g+1] ^ r[g+2];
        ci = ((r[g] & r[g+1]) | (r[g] & r[g+2]) | (r[g+1] & r[g+2])) << 1;
        o[k] = t ^ r[g+3] ^ ci;
        o[k+1] = ((t & r[g+3]) | (t & ci) | (r[g+3] & ci)) << 1;
        k += 2;
      end
    if (m - b == 3) begin
      o[k] = r[b] ^ r[b+1] ^ r[b+2];
      o[k+1] = ((r[b] & r[b+1]) | (r[b] & r[b+2]) | (r[b+1] & r[b+2])) << 1;
    end else
      for (int i = 0; i < 2; i++)
        if (b + i < m) o[k+i] = r[b+i];
    return o;
  endfunction
  logic [N-1:0] ae, be;
  rows_t t1, t2;
  int m1, m2;
  logic [7:0][W-1:0] s1_r;
  logic s1_v, s1_hi, s2_v, s2_hi, out_valid_q, adv;
  logic [TAG_W-1:0] s1_tag, s2_tag;
  logic [W-1:0] s2_s, s2_c, p;
  assign adv = ~out_valid_q | out_ready;
  assign in_ready = adv & ~flush;
  assign out_valid = out_valid_q & ~flush;
  assign ae = {((in_op == 2'b01) || (in_op == 2'b10)) & in_a[XLEN-1], in_a};
  assign be = {(in_op == 2'b01) & in_b[XLEN-1], in_b};
  assign p = s2_s + s2_c;
  always_comb begin
    t1 = gen_pp(ae, be);
    m1 = N;
    for (int l = 0; l < N; l++)
      if (m1 > 8) begin
        t1 = reduce(t1, m1);
        m1 = nxt(m1);
      end
  end
  always_comb begin
    t2 = '0;
    t2[7:0] = s1_r;
    m2 = M1;
    for (int l = 0; l < 8; l++)
      if (m2 > 2) begin
        t2 = reduce(t2, m2);
        m2 = nxt(m2);
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {s1_v, s2_v, out_valid_q, s1_hi, s2_hi} <= '0;
      s1_r <= '0;
      s1_tag <= '0;
      s2_tag <= '0;
      s2_s <= '0;
      s2_c <= '0;
      out_data <= '0;
      out_tag <= '0;
    end else begin
      if (flush) {s1_v, s2_v, out_valid_q} <= '0;
      else if (adv) {s1_v, s2_v, out_valid_q} <= {in_valid, s1_v, s2_v};
      if (adv) begin
        s1_r <= t1[7:0];
        s1_hi <= |in_op;
        s1_tag <= in_tag;
        s2_s <= t2[0];
        s2_c <= t2[1];
        s2_hi <= s1_hi;
        s2_tag <= s1_tag;
        out_data <= s2_hi ? p[2*XLEN-1:XLEN] : p[XLEN-1:0];
        out_tag <= s2_tag;
      end
    end
endmodule

// File: tb/tb_mul_c42_pipe.sv
// tb_mul_c42_pipe: vector table, back-pressure, flush, reset and random scoreboard checks for mul_c42_pipe
module tb_mul_c42_pipe;
  localparam int X = 32;
  localparam int T = 5;
  logic clk = 0, rst_n = 1, flush = 0, in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic [1:0] in_op = 0;
  logic [X-1:0] in_a = 0, in_b = 0, out_data;
  logic [T-1:0] in_tag = 0, out_tag;
  int total = 0, bad = 0, outs = 0;
  typedef struct { logic [X-1:0] d; logic [T-1:0] t; } sb_t;
  typedef struct { logic [1:0] op; logic [X-1:0] a; logic [X-1:0] b; logic [X-1:0] y; } vec_t;
  sb_t q[$];
  always #5 clk = ~clk;
  mul_c42_pipe #(.XLEN(X), .TAG_W(T)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );
  function automatic logic [X-1:0] model(input logic [1:0] op, input logic [X-1:0] a, input logic [X-1:0] b);
    logic signed [X:0] sa, sb;
    logic signed [2*X+1:0] pr;
    sa = {((op == 2'b01) || (op == 2'b10)) & a[X-1], a};
    sb = {(op == 2'b01) & b[X-1], b};
    pr = sa * sb;
    return (op == 2'b00) ? pr[X-1:0] : pr[2*X-1:X];
  endfunction
  function automatic logic [X-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'hffffffff;
      2: return 32'h80000000;
      3: return 32'h7fffffff;
      default: return $urandom;
    endcase
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    sb_t e;
    if (!rst_n || flush) q.delete();
    else begin
      if (out_valid && out_ready) begin
        outs++;
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected got tag=%0d data=%h want=no output t=%0t", out_tag, out_data, $time);
        end else begin
          e = q.pop_front();
          chk("sb_data", out_data, e.d);
          chk("sb_tag", out_tag, e.t);
        end
      end
      if (in_valid && in_ready) q.push_back('{model(in_op, in_a, in_b), in_tag});
    end
  end
  task automatic send(input logic [1:0] op, input logic [X-1:0] a, input logic [X-1:0] b, input logic [T-1:0] tag);
    int n;
    logic acc;
    n = 0;
    in_valid = 1;
    in_op = op;
    in_a = a;
    in_b = b;
    in_tag = tag;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 0;
  endtask
  initial begin
    vec_t v[12];
    int o0, k;
    logic acc;
    logic [X-1:0] hd;
    v[0]  = '{2'b00, 32'h80000000, 32'hffffffff, 32'h80000000};
    v[1]  = '{2'b01, 32'hffffffff, 32'hffffffff, 32'h00000000};
    v[2]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000};
    v[3]  = '{2'b11, 32'hffffffff, 32'hffffffff, 32'hfffffffe};
    v[4]  = '{2'b10, 32'hffffffff, 32'hffffffff, 32'hffffffff};
    v[5]  = '{2'b00, 32'h00000007, 32'h00000006, 32'h0000002a};
    v[6]  = '{2'b11, 32'h80000000, 32'h00000002, 32'h00000001};
    v[7]  = '{2'b01, 32'hffffffff, 32'h00000001, 32'hffffffff};
    v[8]  = '{2'b11, 32'hffffffff, 32'h00000001, 32'h00000000};
    v[9]  = '{2'b10, 32'h80000000, 32'hffffffff, 32'h80000000};
    v[10] = '{2'b00, 32'h0000ffff, 32'h0000ffff, 32'hfffe0001};
    v[11] = '{2'b01, 32'h7fffffff, 32'h7fffffff, 32'h3fffffff};
    #1 rst_n = 0;
    #1;
    chk("rst_ov", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_tag", out_tag, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    @(posedge clk);
    #1;
    chk("idle_ready", in_ready, 1);
    chk("idle_ov", out_valid, 0);
    chk("idle_data", out_data, 0);
    foreach (v[i]) begin
      send(v[i].op, v[i].a, v[i].b, T'(i));
      @(posedge clk);
      #1;
      chk("lat_early", out_valid, 0);
      @(posedge clk);
      #1;
      chk("vec_valid", out_valid, 1);
      chk("vec_data", out_data, v[i].y);
      chk("vec_tag", out_tag, T'(i));
      @(posedge clk);
      #1;
    end
    o0 = outs;
    k = 0;
    hd = '0;
    for (int c = 0; c < 20; c++) begin
      out_ready = !(c >= 4 && c <= 7);
      in_valid = k < 6;
      in_tag = T'(k + 1);
      in_op = 2'(k);
      in_a = pick();
      in_b = pick();
      @(negedge clk);
      if (c >= 4 && c <= 7) begin
        chk("bp_valid", out_valid, 1);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_tag", out_tag, 2);
        if (c > 4) chk("bp_data_stable", out_data, hd);
        hd = out_data;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) k++;
    end
    in_valid = 0;
    out_ready = 1;
    chk("bp_count", outs - o0, 6);
    chk("bp_empty", q.size(), 0);
    send(2'b00, 32'd3, 32'd5, 5'd10);
    send(2'b01, 32'hfffffffe, 32'd3, 5'd11);
    send(2'b11, 32'hffffffff, 32'd2, 5'd12);
    flush = 1;
    @(negedge clk);
    chk("flush_ov", out_valid, 0);
    chk("flush_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    flush = 0;
    chk("post_flush_ov", out_valid, 0);
    send(2'b10, 32'hfffffffd, 32'h00000010, 5'd13);
    chk("flush_q0", out_valid, 0);
    @(posedge clk);
    #1;
    chk("flush_q1", out_valid, 0);
    @(posedge clk);
    #1;
    chk("after_flush_valid", out_valid, 1);
    chk("after_flush_tag", out_tag, 13);
    chk("after_flush_data", out_data, 32'hffffffff);
    @(posedge clk);
    #1;
    send(2'b11, 32'hdeadbeef, 32'h12345678, 5'd7);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    @(posedge clk);
    #2 rst_n = 1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_ov", out_valid, 0);
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < 10000; c++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_op = 2'($urandom);
      in_a = pick();
      in_b = pick();
      in_tag = T'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 49) == 0;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    flush = 0;
    out_ready = 1;
    repeat (8) @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 0);
    chk("drain_ov", out_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
